// File: rtl/ldl_pkg.sv
// Shared types for the ldl arbitration blocks.
// Latency: n/a (types only).
// Backpressure: n/a.
package ldl_pkg;

    // Arbitration policy: lowest index always wins, or search starts just after the last winner
    typedef enum logic {
        LDL_PRI_FIXED = 1'b0,
        LDL_PRI_RR    = 1'b1
    } ldl_pri_mode_e;

endpackage

// File: rtl/ldl_hot2bin_mask.sv
// Finds the first set bit of x at or above ptr, wrapping to the lowest set bit of x.
// Latency: purely combinational.
// Backpressure: none; found=0 when x is empty (w is then 0).
module ldl_hot2bin_mask #(
    parameter int BIN_WIDTH = 4,
    parameter int HOT_WIDTH = 1 << BIN_WIDTH
) (
    input  logic [HOT_WIDTH-1:0] x,
    input  logic [BIN_WIDTH-1:0] ptr,
    output logic [BIN_WIDTH-1:0] w,
    output logic                 found
);

    logic [HOT_WIDTH-1:0] masked;
    logic [BIN_WIDTH-1:0] w_msk;
    logic [BIN_WIDTH-1:0] w_all;

    // Two lowest-index searches: one over bits >= ptr, one over all of x as the wrap fallback
    always_comb begin
        masked = x & ({HOT_WIDTH{1'b1}} << ptr);
        w_msk  = '0;
        w_all  = '0;
        for (int i = HOT_WIDTH - 1; i >= 0; i--) begin
            if (masked[i]) w_msk = BIN_WIDTH'(i);
            if (x[i])      w_all = BIN_WIDTH'(i);
        end
        found = |x;
        w     = (|masked) ? w_msk : w_all;
    end

endmodule

// File: rtl/ldl_hot2bin_rr.sv
// Registered priority encoder/arbiter: one set bit of x -> binary index y plus one-hot y_hot.
// Latency: request seen in cycle n appears on y/valid in cycle n+1; one capture per cycle.
// Backpressure: valid && !ready freezes y/y_hot/valid/ptr and holds x_ack at 0.
module ldl_hot2bin_rr
    import ldl_pkg::*;
#(
    parameter int            BIN_WIDTH = 4,
    parameter int            HOT_WIDTH = 1 << BIN_WIDTH,
    parameter ldl_pri_mode_e MODE      = LDL_PRI_RR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HOT_WIDTH-1:0] x,
    output logic [HOT_WIDTH-1:0] x_ack,
    output logic [BIN_WIDTH-1:0] y,
    output logic [HOT_WIDTH-1:0] y_hot,
    output logic                 valid,
    input  logic                 ready
);

    localparam logic [BIN_WIDTH-1:0] LAST = BIN_WIDTH'(HOT_WIDTH - 1);

    logic [BIN_WIDTH-1:0] ptr;
    logic [BIN_WIDTH-1:0] w;
    logic                 found;
    logic                 load;
    logic                 capture;
    logic [HOT_WIDTH-1:0] w_hot;

    ldl_hot2bin_mask #(
        .BIN_WIDTH (BIN_WIDTH),
        .HOT_WIDTH (HOT_WIDTH)
    ) u_mask (
        .x     (x),
        .ptr   (ptr),
        .w     (w),
        .found (found)
    );

    // Load whenever the output slot is empty or being drained; ack only a real capture outside reset
    always_comb begin
        load    = !valid || ready;
        capture = load && found && !rst;
        w_hot   = '0;
        for (int j = 0; j < HOT_WIDTH; j++) begin
            w_hot[j] = (w == BIN_WIDTH'(j));
        end
        x_ack = capture ? w_hot : '0;
    end

    // Output register and round-robin pointer; pointer only moves on an actual capture
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            y     <= '0;
            y_hot <= '0;
            ptr   <= '0;
        end else if (load) begin
            valid <= found;
            y     <= found ? w : '0;
            y_hot <= found ? w_hot : '0;
            if (found && (MODE == LDL_PRI_RR)) begin
                ptr <= (w == LAST) ? '0 : w + 1'b1;
            end
        end
    end

endmodule
